// File: rtl/secded_decoder_if.sv
// Handshake bundle for the SECDED decoder: codeword in, decoded word out.
interface secded_decoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] out_syn;
   logic       out_sgl;
   logic       out_dbl;

   // Producer of codewords / consumer of decoded words
   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_data, out_syn, out_sgl, out_dbl
   );

   // The decoder itself
   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_data, out_syn, out_sgl, out_dbl
   );
endinterface

// File: rtl/secded_decoder.sv
// Extended-Hamming (8,4) SECDED decoder, two-stage valid/ready pipeline.
// Stage 1 holds the raw codeword with its syndrome and overall parity;
// stage 2 holds the corrected data and error flags. Saturating counters
// tally single / double error words as they leave the block.
module secded_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   secded_decoder_if.slave  bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_sgl,
   output logic [CNT_W-1:0] cnt_dbl
);

   // codeword layout: [7]=d3 [6]=d2 [5]=d1 [4]=p4 [3]=d0 [2]=p2 [1]=p1 [0]=p0
   logic       s1_valid;
   logic [7:0] s1_code;
   logic [2:0] s1_syn;
   logic       s1_par;

   logic       out_valid;
   logic [3:0] out_data;
   logic [2:0] out_syn;
   logic       out_sgl;
   logic       out_dbl;

   logic       s1_load;
   logic       s2_load;
   logic       out_hs;
   logic [2:0] in_syn;
   logic       in_par;
   logic [7:0] fixed;
   logic       fix_sgl;
   logic       fix_dbl;

   // Backpressure ripples from the output; in_ready never looks at in_valid.
   assign s2_load      = !out_valid || bus.out_ready;
   assign s1_load      = !s1_valid || s2_load;
   assign bus.in_ready = s1_load;
   assign out_hs       = out_valid && bus.out_ready;

   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_syn   = out_syn;
   assign bus.out_sgl   = out_sgl;
   assign bus.out_dbl   = out_dbl;

   // Syndrome bits and overall parity of the incoming codeword
   always_comb begin
      in_syn[0] = bus.in_code[1] ^ bus.in_code[3] ^ bus.in_code[5] ^ bus.in_code[7];
      in_syn[1] = bus.in_code[2] ^ bus.in_code[3] ^ bus.in_code[6] ^ bus.in_code[7];
      in_syn[2] = bus.in_code[4] ^ bus.in_code[5] ^ bus.in_code[6] ^ bus.in_code[7];
      in_par    = ^bus.in_code;
   end

   // Stage 1: capture codeword, syndrome and parity
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_code <= bus.in_code;
            s1_syn  <= in_syn;
            s1_par  <= in_par;
         end
      end
   end

   // Classify and correct: odd parity means one flipped bit at position s
   // (s==0 is p0 itself); even parity with nonzero s is uncorrectable.
   always_comb begin
      fixed   = s1_code;
      fix_sgl = 1'b0;
      fix_dbl = 1'b0;
      if (s1_par) begin
         fix_sgl = 1'b1;
         fixed   = s1_code ^ (8'd1 << s1_syn);
      end else if (s1_syn != 3'd0) begin
         fix_dbl = 1'b1;
      end
   end

   // Stage 2: register decoded word; holds steady while the consumer stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_syn   <= '0;
         out_sgl   <= 1'b0;
         out_dbl   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= {fixed[7], fixed[6], fixed[5], fixed[3]};
            out_syn  <= s1_syn;
            out_sgl  <= fix_sgl;
            out_dbl  <= fix_dbl;
         end
      end
   end

   // Saturating event counters; clear beats a same-cycle increment
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_sgl <= '0;
         cnt_dbl <= '0;
      end else if (cnt_clr) begin
         cnt_sgl <= '0;
         cnt_dbl <= '0;
      end else if (out_hs) begin
         if (out_sgl && (cnt_sgl != '1)) cnt_sgl <= cnt_sgl + 1'b1;
         if (out_dbl && (cnt_dbl != '1)) cnt_dbl <= cnt_dbl + 1'b1;
      end
   end

endmodule

// File: tb/tb_secded_decoder.sv
// Self-checking bench for secded_decoder: fixed vector table, exhaustive
// single-flip stream, random backpressured stream, counter and reset corners.
module tb_secded_decoder;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rstn;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_sgl;
   logic [CNT_W-1:0] cnt_dbl;

   secded_decoder_if bus ();

   secded_decoder #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .bus     (bus),
      .cnt_clr (cnt_clr),
      .cnt_sgl (cnt_sgl),
      .cnt_dbl (cnt_dbl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int sc = 0;             // expected cnt_sgl
   int dc = 0;             // expected cnt_dbl
   logic [7:0] src[$];     // codewords waiting to be streamed

   typedef struct {
      logic [7:0] code;
      logic [3:0] data;
      logic [2:0] syn;
      logic       sgl;
      logic       dbl;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
   endfunction

   // Codeword built so that XOR of positions of all set bits 1..7 is zero,
   // then p0 makes the whole byte even.
   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] c;
      int x;
      c = '0;
      c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
      x = 0;
      for (int i = 3; i < 8; i++) if (c[i]) x = x ^ i;
      c[1] = x[0]; c[2] = x[1]; c[4] = x[2];
      c[0] = ^c[7:1];
      return c;
   endfunction

   // Reference decode by nearest codeword: {data, syn, sgl, dbl}
   function automatic logic [8:0] model(input logic [7:0] code);
      int best_d, best_n, n, syn;
      best_d = 0;
      best_n = 9;
      for (int d = 0; d < 16; d++) begin
         n = $countones(code ^ encode(4'(d)));
         if (n < best_n) begin best_n = n; best_d = d; end
      end
      syn = 0;
      for (int i = 1; i < 8; i++) if (code[i]) syn = syn ^ i;
      if (best_n == 0) return {4'(best_d), 3'(syn), 1'b0, 1'b0};
      if (best_n == 1) return {4'(best_d), 3'(syn), 1'b1, 1'b0};
      return {code[7], code[6], code[5], code[3], 3'(syn), 1'b0, 1'b1};
   endfunction

   function automatic logic [8:0] outs();
      return {bus.out_data, bus.out_syn, bus.out_sgl, bus.out_dbl};
   endfunction

   // Stream everything in src, optionally with random gaps and backpressure
   task automatic run_stream(input bit rnd);
      logic [8:0] q[$];
      logic [8:0] e, snap;
      bit stalled, pend;
      int cyc;
      stalled = 0; pend = 0; cyc = 0; snap = '0;
      while ((src.size() != 0 || pend || q.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'(outs()), 32'(snap));
         end
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!pend && src.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            bus.in_code  = src.pop_front();
            bus.in_valid = 1'b1;
            pend = 1;
         end else if (!pend) begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.in_code));
            pend = 0;
         end
         stalled = bus.out_valid && !bus.out_ready;
         if (stalled) snap = outs();
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("stream_out", 32'(outs()), 32'(e));
               if (e[1]) sc = sat(sc);
               if (e[0]) dc = sat(dc);
            end
         end
      end
      if (cyc >= 20000) chk("stream_timeout", 32'd0, 32'd1);
      src.delete();
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("cnt_sgl", 32'(cnt_sgl), 32'(sc));
      chk("cnt_dbl", 32'(cnt_dbl), 32'(dc));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c;
      int b1, b2;

      // clean / single / double cases built by hand from the code rules
      vt[0] = '{8'hFF, 4'hF, 3'd0, 1'b0, 1'b0};
      vt[1] = '{8'hFE, 4'hF, 3'd0, 1'b1, 1'b0};
      vt[2] = '{8'hEF, 4'hF, 3'd4, 1'b1, 1'b0};
      vt[3] = '{8'hEE, 4'hF, 3'd4, 1'b0, 1'b1};
      vt[4] = '{8'h00, 4'h0, 3'd0, 1'b0, 1'b0};
      vt[5] = '{8'h01, 4'h0, 3'd0, 1'b1, 1'b0};
      vt[6] = '{8'h08, 4'h0, 3'd3, 1'b1, 1'b0};
      vt[7] = '{8'h06, 4'h0, 3'd3, 1'b0, 1'b1};
      vt[8] = '{8'h5A, 4'h5, 3'd0, 1'b0, 1'b0};
      vt[9] = '{8'hDA, 4'h5, 3'd7, 1'b1, 1'b0};

      rstn = 1'b0; cnt_clr = 1'b0;
      bus.in_valid = 1'b0; bus.in_code = '0; bus.out_ready = 1'b1;
      #23;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_outs", 32'(outs()), 32'd0);
      chk("rst_cnt_sgl", 32'(cnt_sgl), 32'd0);
      chk("rst_cnt_dbl", 32'(cnt_dbl), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk); rstn = 1'b1;

      // Table: one word at a time, latency of exactly two edges
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_code = vt[i].code;
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk("tbl_lat1", 32'(bus.out_valid), 32'd0);
         @(negedge clk);
         chk("tbl_valid", 32'(bus.out_valid), 32'd1);
         chk("tbl_out", 32'(outs()), 32'({vt[i].data, vt[i].syn, vt[i].sgl, vt[i].dbl}));
         if (vt[i].sgl) sc = sat(sc);
         if (vt[i].dbl) dc = sat(dc);
      end
      @(negedge clk);
      chk("tbl_cnt_sgl", 32'(cnt_sgl), 32'(sc));
      chk("tbl_cnt_dbl", 32'(cnt_dbl), 32'(dc));

      // Every data value, clean and with each single-bit flip, back to back
      for (int d = 0; d < 16; d++)
         for (int f = -1; f < 8; f++) begin
            c = encode(4'(d));
            if (f >= 0) c[f] = ~c[f];
            src.push_back(c);
         end
      run_stream(1'b0);

      // Random mix of clean / single / double words under random backpressure
      for (int i = 0; i < 200; i++) begin
         c = encode(4'($urandom_range(0, 15)));
         b1 = $urandom_range(0, 7);
         b2 = (b1 + $urandom_range(1, 7)) % 8;
         case ($urandom_range(0, 2))
            1: c[b1] = ~c[b1];
            2: begin c[b1] = ~c[b1]; c[b2] = ~c[b2]; end
            default: ;
         endcase
         src.push_back(c);
      end
      run_stream(1'b1);

      // Reset with both stages full: everything in flight is dropped
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_code = 8'hFE;
      repeat (3) @(negedge clk);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_outs", 32'(outs()), 32'd0);
      chk("mid_rst_cnt", 32'({cnt_sgl, cnt_dbl}), 32'd0);
      sc = 0; dc = 0;
      @(negedge clk);
      rstn = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
      end

      // Saturation: more single-error words than the counter can hold
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         c = encode(4'($urandom_range(0, 15)));
         b1 = $urandom_range(0, 7);
         c[b1] = ~c[b1];
         src.push_back(c);
      end
      run_stream(1'b0);
      chk("sat_cnt_sgl", 32'(cnt_sgl), 32'hFF);

      // Clear coinciding with a single-error handshake wins
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_code = 8'hFE;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("clr_pre_valid", 32'(bus.out_valid), 32'd1);
      cnt_clr = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      sc = 0; dc = 0;
      chk("clr_cnt_sgl", 32'(cnt_sgl), 32'd0);
      chk("clr_out_valid", 32'(bus.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
